// File: rtl/motor_pkg.sv
// motor_pkg: shared encodings and helpers for the motor drive sequencer.
// Command and state enums, preset selection and the saturating ramp step.
package motor_pkg;

  typedef enum logic [2:0] {
    CMD_STOP  = 3'd0,
    CMD_FWD   = 3'd1,
    CMD_REV   = 3'd2,
    CMD_RIGHT = 3'd3,
    CMD_LEFT  = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RAMP,
    ST_BRAKE,
    ST_DEAD
  } state_e;

  // Which preset duty a side should head for.
  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_FWD,
    SEL_HI,
    SEL_LO
  } sel_e;

  typedef struct packed {
    sel_e l;
    sel_e r;
    logic dir;
    logic err;
  } preset_t;

  // Map a command code to per-side presets and direction.
  // STOP and illegal codes keep the current direction.
  function automatic preset_t cmd_preset(
    input logic [2:0] c,
    input logic       cur_dir
  );
    preset_t p;
    p.l   = SEL_ZERO;
    p.r   = SEL_ZERO;
    p.dir = cur_dir;
    p.err = 1'b0;
    case (c)
      CMD_STOP: ;
      CMD_FWD: begin
        p.l   = SEL_FWD;
        p.r   = SEL_FWD;
        p.dir = 1'b1;
      end
      CMD_REV: begin
        p.l   = SEL_FWD;
        p.r   = SEL_FWD;
        p.dir = 1'b0;
      end
      CMD_RIGHT: begin
        p.l   = SEL_HI;
        p.r   = SEL_LO;
        p.dir = 1'b1;
      end
      CMD_LEFT: begin
        p.l   = SEL_LO;
        p.r   = SEL_HI;
        p.dir = 1'b1;
      end
      default: p.err = 1'b1;
    endcase
    return p;
  endfunction

  // Move d toward t by at most s, landing exactly on t.
  // The difference is taken one bit wider so it never wraps.
  function automatic logic [31:0] ramp_step(
    input logic [31:0] d,
    input logic [31:0] t,
    input logic [31:0] s
  );
    logic [32:0] diff;
    logic [31:0] r;
    if (t >= d) begin
      diff = {1'b0, t} - {1'b0, d};
      r    = (diff <= {1'b0, s}) ? t : d + s;
    end else begin
      diff = {1'b0, d} - {1'b0, t};
      r    = (diff <= {1'b0, s}) ? t : d - s;
    end
    return r;
  endfunction

endpackage

// File: rtl/motor_drive_sequencer_pwm_channel.sv
// pwm_channel: one side's duty register, ramp step and PWM compare.
// Duty moves only on period_tick so each period sees a single value.
module pwm_channel
  import motor_pkg::*;
#(
  parameter int CW        = 20,
  parameter int PERIOD    = 1000000,
  parameter int RAMP_STEP = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cnt,
  input  logic          tick,
  input  logic          clr,
  input  logic [CW-1:0] target,
  output logic [CW-1:0] duty,
  output logic [CW-1:0] duty_nxt,
  output logic          pwm
);

  localparam int CW1 = CW + 1;
  localparam logic [CW:0] PER = CW1'(PERIOD);

  logic [CW-1:0] duty_q, duty_d;
  logic [CW:0]   duty_c;
  logic          pwm_q, pwm_d;

  // Duty after one ramp step toward the target.
  assign duty_nxt = CW'(ramp_step(32'(duty_q), 32'(target), 32'(RAMP_STEP)));

  // Next duty and clamped compare for the output register.
  always_comb begin
    duty_d = duty_q;
    if (clr) begin
      duty_d = '0;
    end else if (tick) begin
      duty_d = duty_nxt;
    end
    duty_c = ({1'b0, duty_q} >= PER) ? PER : {1'b0, duty_q};
    pwm_d  = ({1'b0, cnt} < duty_c);
  end

  // Duty and PWM registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign duty = duty_q;
  assign pwm  = pwm_q;

endmodule

// File: rtl/motor_drive_sequencer.sv
// motor_drive_sequencer: command handshake, ramp/brake/dead-time FSM
// and the shared PWM period counter driving two pwm_channel sides.
module motor_drive_sequencer
  import motor_pkg::*;
#(
  parameter int CW           = 20,
  parameter int PERIOD       = 1000000,
  parameter int DUTY_FWD     = 750000,
  parameter int DUTY_HI      = 800000,
  parameter int DUTY_LO      = 400000,
  parameter int RAMP_STEP    = 50000,
  parameter int DEAD_PERIODS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  output logic          cmd_err,
  output logic          pwm_l,
  output logic          pwm_r,
  output logic          dir_l,
  output logic          dir_r,
  output logic [CW-1:0] duty_l,
  output logic [CW-1:0] duty_r,
  output logic          busy,
  output logic          period_tick
);

  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] D_FWD = CW'(DUTY_FWD);
  localparam logic [CW-1:0] D_HI = CW'(DUTY_HI);
  localparam logic [CW-1:0] D_LO = CW'(DUTY_LO);
  localparam int DW = $clog2(DEAD_PERIODS + 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_PERIODS - 1);

  function automatic logic [CW-1:0] sel_val(input sel_e s);
    logic [CW-1:0] v;
    unique case (s)
      SEL_FWD: v = D_FWD;
      SEL_HI:  v = D_HI;
      SEL_LO:  v = D_LO;
      default: v = '0;
    endcase
    return v;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [CW-1:0] tgt_l_q, tgt_l_d;
  logic [CW-1:0] tgt_r_q, tgt_r_d;
  logic          tgt_dir_q, tgt_dir_d;
  logic          dir_q, dir_d;
  logic [DW-1:0] dead_q, dead_d;
  logic          err_q, err_d;

  logic          tick;
  logic          accept;
  preset_t       p;
  logic [CW-1:0] new_l, new_r;
  logic          dir_chg;
  logic          duties_zero;
  logic [CW-1:0] ch_tgt_l, ch_tgt_r;
  logic [CW-1:0] nxt_l, nxt_r;
  logic          at_tgt;
  logic          clr;

  assign tick        = (cnt_q == LAST);
  assign cmd_ready   = (state_q == ST_HOLD) || (state_q == ST_RAMP);
  assign accept      = cmd_valid && cmd_ready;
  assign p           = cmd_preset(cmd, dir_q);
  assign new_l       = sel_val(p.l);
  assign new_r       = sel_val(p.r);
  assign dir_chg     = (p.dir != dir_q);
  assign duties_zero = (duty_l == '0) && (duty_r == '0);

  // Braking heads for zero; otherwise the channels chase the targets.
  assign ch_tgt_l = (state_q == ST_BRAKE) ? '0 : tgt_l_q;
  assign ch_tgt_r = (state_q == ST_BRAKE) ? '0 : tgt_r_q;
  assign at_tgt   = (nxt_l == ch_tgt_l) && (nxt_r == ch_tgt_r);
  assign clr      = (state_d == ST_DEAD);

  // Free-running period counter.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Next-state, target capture, direction and dead-time counting.
  always_comb begin
    state_d   = state_q;
    tgt_l_d   = tgt_l_q;
    tgt_r_d   = tgt_r_q;
    tgt_dir_d = tgt_dir_q;
    dir_d     = dir_q;
    dead_d    = dead_q;
    err_d     = 1'b0;
    unique case (state_q)
      ST_HOLD, ST_RAMP: begin
        if (accept) begin
          tgt_l_d   = new_l;
          tgt_r_d   = new_r;
          tgt_dir_d = p.dir;
          err_d     = p.err;
          if (!dir_chg) begin
            state_d = ST_RAMP;
          end else if (duties_zero) begin
            state_d = ST_DEAD;
            dir_d   = p.dir;
            dead_d  = '0;
          end else begin
            state_d = ST_BRAKE;
          end
        end else if (state_q == ST_RAMP && tick && at_tgt) begin
          state_d = ST_HOLD;
        end
      end
      ST_BRAKE: begin
        if (tick && at_tgt) begin
          state_d = ST_DEAD;
          dir_d   = tgt_dir_q;
          dead_d  = '0;
        end
      end
      ST_DEAD: begin
        if (tick) begin
          if (dead_q == DEAD_LAST) begin
            state_d = ST_RAMP;
          end else begin
            dead_d = dead_q + DW'(1);
          end
        end
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      state_q   <= ST_HOLD;
      tgt_l_q   <= '0;
      tgt_r_q   <= '0;
      tgt_dir_q <= 1'b1;
      dir_q     <= 1'b1;
      dead_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      tgt_l_q   <= tgt_l_d;
      tgt_r_q   <= tgt_r_d;
      tgt_dir_q <= tgt_dir_d;
      dir_q     <= dir_d;
      dead_q    <= dead_d;
      err_q     <= err_d;
    end
  end

  pwm_channel #(
    .CW        (CW),
    .PERIOD    (PERIOD),
    .RAMP_STEP (RAMP_STEP)
  ) u_left (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt_q),
    .tick     (tick),
    .clr      (clr),
    .target   (ch_tgt_l),
    .duty     (duty_l),
    .duty_nxt (nxt_l),
    .pwm      (pwm_l)
  );

  pwm_channel #(
    .CW        (CW),
    .PERIOD    (PERIOD),
    .RAMP_STEP (RAMP_STEP)
  ) u_right (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt_q),
    .tick     (tick),
    .clr      (clr),
    .target   (ch_tgt_r),
    .duty     (duty_r),
    .duty_nxt (nxt_r),
    .pwm      (pwm_r)
  );

  assign cmd_err     = err_q;
  assign dir_l       = dir_q;
  assign dir_r       = dir_q;
  assign busy        = (state_q != ST_HOLD);
  assign period_tick = tick;

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// tb_motor_drive_sequencer: directed and random commands checked
// against a period-level behavioural model of the sequencer.
module tb_motor_drive_sequencer;

  localparam int P  = 100;
  localparam int DF = 75;
  localparam int DH = 80;
  localparam int DL = 40;
  localparam int RS = 25;
  localparam int DP = 2;

  localparam int MM_RUN   = 0;
  localparam int MM_BRAKE = 1;
  localparam int MM_DEAD  = 2;

  localparam int PRE_L [8] = '{0, DF, DF, DH, DL, 0, 0, 0};
  localparam int PRE_R [8] = '{0, DF, DF, DL, DH, 0, 0, 0};

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_err;
  logic        pwm_l;
  logic        pwm_r;
  logic        dir_l;
  logic        dir_r;
  logic [19:0] duty_l;
  logic [19:0] duty_r;
  logic        busy;
  logic        period_tick;

  int total = 0;
  int bad   = 0;

  int md_l, md_r, t_l, t_r;
  int m_mode, m_dead, m_cnt;
  bit m_dir, t_dir, m_settled, m_err;

  motor_drive_sequencer #(
    .CW           (20),
    .PERIOD       (P),
    .DUTY_FWD     (DF),
    .DUTY_HI      (DH),
    .DUTY_LO      (DL),
    .RAMP_STEP    (RS),
    .DEAD_PERIODS (DP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_err     (cmd_err),
    .pwm_l       (pwm_l),
    .pwm_r       (pwm_r),
    .dir_l       (dir_l),
    .dir_r       (dir_r),
    .duty_l      (duty_l),
    .duty_r      (duty_r),
    .busy        (busy),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=progress", tag);
  endtask

  function automatic int rstep(input int d, input int t);
    int df;
    df = (t > d) ? t - d : d - t;
    if (df <= RS) return t;
    return (d < t) ? d + RS : d - RS;
  endfunction

  task automatic m_reset;
    md_l = 0; md_r = 0; t_l = 0; t_r = 0;
    m_dir = 1; t_dir = 1;
    m_mode = MM_RUN; m_dead = 0; m_cnt = 0;
    m_settled = 1; m_err = 0;
  endtask

  // One period boundary of the model.
  task automatic m_tick;
    case (m_mode)
      MM_RUN: begin
        md_l = rstep(md_l, t_l);
        md_r = rstep(md_r, t_r);
        if (md_l == t_l && md_r == t_r) m_settled = 1;
      end
      MM_BRAKE: begin
        md_l = rstep(md_l, 0);
        md_r = rstep(md_r, 0);
        if (md_l == 0 && md_r == 0) begin
          m_mode = MM_DEAD;
          m_dir  = t_dir;
          m_dead = 0;
        end
      end
      default: begin
        m_dead++;
        if (m_dead == DP) begin
          m_mode = MM_RUN;
          md_l = rstep(md_l, t_l);
          md_r = rstep(md_r, t_r);
        end
      end
    endcase
  endtask

  task automatic m_accept(input int c);
    bit nd;
    if (c == 2) nd = 0;
    else if (c == 1 || c == 3 || c == 4) nd = 1;
    else nd = m_dir;
    t_l = PRE_L[c];
    t_r = PRE_R[c];
    t_dir = nd;
    m_err = (c > 4);
    m_settled = 0;
    if (nd != m_dir) begin
      if (md_l == 0 && md_r == 0) begin
        m_mode = MM_DEAD;
        m_dir  = nd;
        m_dead = 0;
      end else begin
        m_mode = MM_BRAKE;
      end
    end
  endtask

  // One clock: drive, advance model at the edge, check at negedge.
  task automatic cyc(input bit v, input logic [2:0] c);
    int pc, pdl, pdr;
    bit tk, rdy;
    cmd_valid = v;
    cmd = c;
    pc = m_cnt;
    pdl = (md_l > P) ? P : md_l;
    pdr = (md_r > P) ? P : md_r;
    @(posedge clk);
    m_err = 0;
    tk = (m_cnt == P - 1);
    rdy = (m_mode == MM_RUN);
    if (tk) m_tick();
    if (v && rdy) m_accept(int'(c));
    m_cnt = tk ? 0 : m_cnt + 1;
    @(negedge clk);
    cmd_valid = 0;
    chk("tick", period_tick, m_cnt == P - 1);
    chk("ready", cmd_ready, m_mode == MM_RUN);
    chk("busy", busy, !m_settled);
    chk("duty_l", duty_l, md_l);
    chk("duty_r", duty_r, md_r);
    chk("dir_l", dir_l, m_dir);
    chk("dir_r", dir_r, m_dir);
    chk("err", cmd_err, m_err);
    chk("pwm_l", pwm_l, pc < pdl);
    chk("pwm_r", pwm_r, pc < pdr);
  endtask

  task automatic issue(input logic [2:0] c);
    int n = 0;
    while (!(m_mode == MM_RUN && m_cnt != P - 1) && n < 2000) begin
      cyc(0, 0);
      n++;
    end
    if (n >= 2000) timeout("issue_wait");
    cyc(1, c);
  endtask

  task automatic wait_tick;
    do cyc(0, 0); while (m_cnt != 0);
  endtask

  task automatic wait_idle;
    int n = 0;
    while (!m_settled && n < 5000) begin
      cyc(0, 0);
      n++;
    end
    if (n >= 5000) timeout("idle_wait");
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_pwm_l"}, pwm_l, 0);
    chk({tag, "_pwm_r"}, pwm_r, 0);
    chk({tag, "_duty_l"}, duty_l, 0);
    chk({tag, "_duty_r"}, duty_r, 0);
    chk({tag, "_dir_l"}, dir_l, 1);
    chk({tag, "_dir_r"}, dir_r, 1);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tick"}, period_tick, 0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    int hc;
    int n;
    rst = 1'b1;
    cmd = 3'd0;
    cmd_valid = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_duty_l", duty_l, 0);
    chk("rst_duty_r", duty_r, 0);
    chk("rst_pwm_l", pwm_l, 0);
    chk("rst_dir_l", dir_l, 1);
    chk("rst_dir_r", dir_r, 1);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_err", cmd_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", period_tick, 0);
    rst = 1'b0;

    // FWD ramp from rest
    issue(3'd1);
    wait_tick();
    chk("fwd_s1", duty_l, 25);
    chk("fwd_s1_busy", busy, 1);
    wait_tick();
    chk("fwd_s2", duty_r, 50);
    wait_tick();
    chk("fwd_s3", duty_l, 75);
    chk("fwd_s3_busy", busy, 0);
    hc = 0;
    repeat (P) begin
      cyc(0, 0);
      hc += int'(pwm_l);
    end
    chk("fwd_high_cnt", hc, 75);

    // RIGHT from FWD hold: no dead time
    issue(3'd3);
    wait_tick();
    chk("right_l", duty_l, 80);
    chk("right_r1", duty_r, 50);
    wait_tick();
    chk("right_r2", duty_r, 40);
    chk("right_dir", dir_r, 1);

    // REV from FWD hold: brake, dead, ramp reversed
    issue(3'd1);
    wait_idle();
    issue(3'd2);
    chk("rev_ready", cmd_ready, 0);
    wait_tick();
    chk("rev_b1", duty_l, 50);
    wait_tick();
    chk("rev_b2", duty_l, 25);
    wait_tick();
    chk("rev_b3", duty_r, 0);
    chk("rev_dir", dir_l, 0);
    wait_tick();
    chk("rev_d1", duty_l, 0);
    wait_tick();
    chk("rev_r1", duty_l, 25);
    chk("rev_r1_dir", dir_r, 0);
    wait_tick();
    wait_tick();
    chk("rev_r3", duty_r, 75);
    chk("rev_r3_busy", busy, 0);

    // Illegal code from FWD hold
    issue(3'd1);
    wait_idle();
    issue(3'd6);
    chk("ill_err_hi", cmd_err, 1);
    cyc(0, 0);
    chk("ill_err_lo", cmd_err, 0);
    wait_idle();
    chk("ill_duty", duty_l, 0);
    chk("ill_dir", dir_l, 1);

    // LEFT mid-ramp at 50
    issue(3'd1);
    wait_tick();
    wait_tick();
    issue(3'd4);
    wait_tick();
    chk("left_l", duty_l, 40);
    chk("left_r1", duty_r, 75);
    wait_tick();
    chk("left_r2", duty_r, 80);

    // LEFT accepted on the tick itself
    issue(3'd0);
    wait_idle();
    issue(3'd1);
    wait_tick();
    wait_tick();
    while (m_cnt != P - 1) cyc(0, 0);
    cyc(1, 3'd4);
    chk("tkacc_l0", duty_l, 75);
    wait_tick();
    chk("tkacc_l1", duty_l, 50);
    chk("tkacc_r1", duty_r, 80);
    wait_tick();
    chk("tkacc_l2", duty_l, 40);

    // Reset mid-ramp while pwm is high
    issue(3'd0);
    wait_idle();
    issue(3'd1);
    wait_tick();
    wait_tick();
    while (m_cnt != 10) cyc(0, 0);
    chk("pre_rst_pwm", pwm_l, 1);
    async_reset("rst_ramp");

    // Reset in dead time
    issue(3'd1);
    wait_idle();
    issue(3'd2);
    n = 0;
    while (m_mode != MM_DEAD && n < 2000) begin
      cyc(0, 0);
      n++;
    end
    if (n >= 2000) timeout("dead_wait");
    repeat (30) cyc(0, 0);
    chk("pre_rst_dir", dir_l, 0);
    async_reset("rst_dead");
    issue(3'd1);
    wait_tick();
    chk("post_rst_l", duty_l, 25);
    chk("post_rst_dir", dir_l, 1);

    // Random command stream
    for (int k = 0; k < 30; k++) begin
      int gap;
      issue(3'($urandom_range(0, 7)));
      gap = $urandom_range(1, 400);
      for (int g = 0; g < gap; g++) begin
        bit v;
        v = (m_mode != MM_RUN) && ($urandom_range(0, 3) == 0);
        cyc(v, 3'($urandom_range(0, 7)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_drive_sequencer.md
# motor_drive_sequencer

Sequences the two drive motors: accepts drive commands (stop, forward, reverse, turn right, turn left) and ramps each side's duty toward that command's preset. Enforces a zero-output dead time before any direction reversal and generates the per-side PWM from one shared period counter. It sits between the navigation logic and the H-bridge pins, replacing fixed, free-running duty constants.

## Interface
Parameters:
- `CW`, 20, width of period counter and duty values.
- `PERIOD`, 1000000, PWM period in clk cycles (1 <= PERIOD <= 2^CW).
- `DUTY_FWD`, 750000, both-side duty for FWD and REV.
- `DUTY_HI`, 800000, outer-side duty during a turn.
- `DUTY_LO`, 400000, inner-side duty during a turn.
- `RAMP_STEP`, 50000, maximum duty change per period, nonzero.
- `DEAD_PERIODS`, 2, zero-output periods at a direction change, >= 1.

Ports:
- `clk`, in, 1, system clock.
- `rst`, in, 1, asynchronous active-high reset.
- `cmd`, in, 3, 0 STOP, 1 FWD, 2 REV, 3 RIGHT, 4 LEFT, 5–7 illegal.
- `cmd_valid`, in, 1, command offered.
- `cmd_ready`, out, 1, command can be accepted.
- `cmd_err`, out, 1, one-cycle pulse when an illegal code is accepted.
- `pwm_l`, `pwm_r`, out, 1, PWM to left/right bridge enable.
- `dir_l`, `dir_r`, out, 1, bridge direction, 1 = forward.
- `duty_l`, `duty_r`, out, CW, currently applied duty.
- `busy`, out, 1, high whenever state != HOLD.
- `period_tick`, out, 1, high in the cycle the counter equals PERIOD-1.

## Operation
- Counter `cnt` runs 0..PERIOD-1 and wraps. `period_tick` = (cnt == PERIOD-1).
- Preset targets (L, R, dir):
  - STOP: 0, 0.
  - FWD: DUTY_FWD, DUTY_FWD, forward.
  - REV: DUTY_FWD, DUTY_FWD, reverse.
  - RIGHT: DUTY_HI, DUTY_LO, forward.
  - LEFT: DUTY_LO, DUTY_HI, forward.
  - Illegal code: treated as STOP and pulses `cmd_err` in the cycle after acceptance.
  - STOP keeps the current direction.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - `cmd_ready` = 1 in HOLD and RAMP, 0 in BRAKE and DEAD.
  - A new command replaces the targets of the previous one.
- States:
  - HOLD: duties equal targets.
    - Accepted cmd with no direction change -> RAMP.
    - Direction change with both duties nonzero -> BRAKE.
    - Direction change with both duties 0 -> DEAD.
  - RAMP: at each period_tick each duty moves toward its target by at most RAMP_STEP, saturating exactly at the target.
    - Both duties at target -> HOLD.
    - Command handling is the same as in HOLD.
  - BRAKE: ramp both duties toward 0 at period_tick. Both 0 -> DEAD.
  - DEAD: duties forced to 0.
    - `dir_l`/`dir_r` take the new direction on entry.
    - Count DEAD_PERIODS period_ticks, then -> RAMP toward the pending targets.
- Ramp arithmetic: if |target − duty| <= RAMP_STEP then duty = target, else duty ± RAMP_STEP. Compute in CW+1 bits; no underflow or overflow.
- PWM output: `pwm_x` = registered (cnt < duty_x).
  - Duty 0 -> never high.
  - Duty >= PERIOD -> clamped to PERIOD, so the output is constantly high.

## Timing
- Reset values: cnt 0, duty_l/r 0, pwm_l/r 0, dir_l/r 1, state HOLD, targets STOP, cmd_ready 1, cmd_err 0, busy 0, period_tick 0.
- Reset takes effect asynchronously. Asserting it mid-ramp or in DEAD forces pwm low immediately.
- Duty registers change only in the cycle after period_tick, so each period uses one duty value with no glitch.
- pwm_x lags cnt by one cycle. Each output is high for exactly duty_x cycles per period.
- Acceptance to state change: 1 cycle. The first duty step happens at the next period_tick.
- Command accepted in the same cycle as period_tick: the new target applies starting at the following period_tick.
- busy falls in the same cycle the state enters HOLD.

## Structure
- Package `motor_pkg`:
  - cmd encoding enum.
  - state enum: HOLD, RAMP, BRAKE, DEAD.
  - function mapping cmd to {target_l, target_r, dir}.
  - saturating ramp-step function.
- Sub-module `pwm_channel`: holds one side's duty register, ramp step and compare/output register. It is instantiated twice and fed the shared cnt and period_tick.
- The top holds the counter, FSM, dead-time counter and handshake.

## Test plan
Use PERIOD=100, DUTY_FWD=75, DUTY_HI=80, DUTY_LO=40, RAMP_STEP=25, DEAD_PERIODS=2.
- Reset release, FWD -> duties 25, 50, 75 at successive ticks; busy falls at 75; pwm high 75 of 100 cycles.
- From FWD HOLD, RIGHT -> L 75→80 and R 75→50→40, dir unchanged, no DEAD.
- From FWD HOLD, REV -> cmd_ready 0; duties 50, 25, 0; dir flips; 2 zero periods; ramp to 75 with dir 0.
- cmd=6 in HOLD at FWD -> cmd_err pulses for 1 cycle; ramps to 0; dir unchanged.
- LEFT accepted during a FWD ramp at 50 -> next tick gives L 40, R 75; then R 80.
- rst asserted in DEAD -> all outputs return to reset values the same cycle; a later FWD ramps from 0.
